axis_rr_mux: RTL and testbench
==============================

AXIS_RR_MUX -- requirements
Module: axis_rr_mux

Interface
REQ-001 Parameter N, default 4, number of slave channels, legal 2..16.
REQ-002 Parameter DW, default 32, tdata width, multiple of 8; SW = DW/8.
REQ-003 Parameters UW/DSTW/IW, defaults 1/1/4, tuser/tdest/tid widths; IW >= clog2(N).
REQ-004 Parameter ID_MODE, default 1: 0 = pass s_tid through, 1 = m_tid is granted channel index, zero-extended.
REQ-005 Clocking SHALL be one clock, clk; reset rst is synchronous and active-high.
REQ-006 clk  in  1  sole clock, all logic on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 s_tdata/s_tkeep/s_tstrb  in  N*DW/N*SW/N*SW  per-channel payload, channel i at slice i.
REQ-009 s_tuser/s_tdest/s_tid  in  N*UW/N*DSTW/N*IW  per-channel sideband.
REQ-010 s_tvalid/s_tlast  in  N each  per-channel valid, end of packet.
REQ-011 s_tready  out  N  per-channel ready.
REQ-012 m_tdata/m_tkeep/m_tstrb/m_tuser/m_tdest/m_tid  out  DW/SW/SW/UW/DSTW/IW  merged stream.
REQ-013 m_tvalid/m_tlast  out  1 each; m_tready  in  1.

Function
REQ-014 Arbitration SHALL be packet-level round robin: two states, IDLE (no lock) and LOCK (channel g owns output).
REQ-015 In IDLE, grant SHALL go to the first channel with s_tvalid high searching g+1, g+2, ... mod N, where g is the last granted channel (reset g = N-1, so channel 0 wins first).
REQ-016 The beat of the winning channel SHALL be accepted in the same cycle as the IDLE decision (no arbitration bubble) when the input stage has space.
REQ-017 IDLE->LOCK on accepted beat with s_tlast=0; remain IDLE (g updated) on accepted beat with s_tlast=1.
REQ-018 LOCK->IDLE on accepted beat of channel g with s_tlast=1; s_tvalid low on g mid-packet SHALL hold LOCK (bubble), never regrant.
REQ-019 s_tready[i] SHALL be high only for the granted/winning channel and only when the skid buffer has a free entry; all other bits 0.
REQ-020 Output SHALL be a 2-entry skid buffer: s_tready not combinationally dependent on m_tready; latency from s handshake to m_tvalid exactly 1 cycle when empty.
REQ-021 Full throughput: with m_tready held 1, one beat per cycle sustained, including back-to-back packets from different channels.
REQ-022 Payload, tkeep, tstrb, tuser, tdest, tlast SHALL pass unmodified; m_tid per ID_MODE.
REQ-023 m_tvalid once high SHALL stay high with stable payload until m_tready (AXIS rule).
REQ-024 Single-beat packets from all N channels simultaneously SHALL be served in order 0..N-1 then wrap, one per cycle.

Reset
REQ-025 On rst: state IDLE, g = N-1, skid buffer empty, m_tvalid=0, s_tready=0, m_* payload outputs 0.
REQ-026 rst mid-packet SHALL discard buffered beats and the lock; first cycle after rst follows REQ-015 from g = N-1.

Structure
REQ-027 Shared package axis_pkg SHALL hold the clog2 helper, default widths, and ID_MODE encoding constants.
REQ-028 The skid buffer SHALL be a sub-module axis_skid_buf (parameters DW/UW/DSTW/IW), reusable elsewhere.

Verification
REQ-029 After rst, channels 0..3 each present 1-beat packets (tdata=0x10+i), m_tready=1 -> m_tdata 0x10,0x11,0x12,0x13 on 4 consecutive cycles, m_tid 0..3.
REQ-030 Channel 1 sends 4-beat packet, channel 2 valid from beat 2 -> all 4 channel-1 beats contiguous, then channel 2; s_tready[2]=0 throughout the lock.
REQ-031 Channel 0 drops s_tvalid for 3 cycles mid-packet while channel 3 valid -> m_tvalid low 3 cycles, lock held, channel 3 served only after channel 0 tlast.
REQ-032 m_tready toggles 1,0,0,1 during burst -> no beat lost/duplicated, m_tdata stable while stalled, s_tready falls only after 2 beats buffered.
REQ-033 rst asserted on beat 2 of 5-beat packet -> next cycle m_tvalid=0, s_tready=0; post-reset grant goes to channel 0 if valid.
REQ-034 ID_MODE=0, channel 2 s_tid=0xA -> m_tid=0xA.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-Stream constants: default widths, ID_MODE encodings, arbiter states
// and a constant-function log2 helper.
package axis_pkg;

   localparam int unsigned AXIS_DEF_N    = 4;
   localparam int unsigned AXIS_DEF_DW   = 32;
   localparam int unsigned AXIS_DEF_UW   = 1;
   localparam int unsigned AXIS_DEF_DSTW = 1;
   localparam int unsigned AXIS_DEF_IW   = 4;

   localparam int unsigned ID_MODE_PASS  = 0;
   localparam int unsigned ID_MODE_INDEX = 1;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer: registered output stage plus one overflow entry,
// so s_tready depends only on local state, never on m_tready.
module axis_skid_buf
   import axis_pkg::*;
#(
   parameter int unsigned DW   = AXIS_DEF_DW,
   parameter int unsigned UW   = AXIS_DEF_UW,
   parameter int unsigned DSTW = AXIS_DEF_DSTW,
   parameter int unsigned IW   = AXIS_DEF_IW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DW-1:0]     s_tdata,
   input  logic [DW/8-1:0]   s_tkeep,
   input  logic [DW/8-1:0]   s_tstrb,
   input  logic [UW-1:0]     s_tuser,
   input  logic [DSTW-1:0]   s_tdest,
   input  logic [IW-1:0]     s_tid,
   input  logic              s_tlast,
   input  logic              s_tvalid,
   output logic              s_tready,
   output logic [DW-1:0]     m_tdata,
   output logic [DW/8-1:0]   m_tkeep,
   output logic [DW/8-1:0]   m_tstrb,
   output logic [UW-1:0]     m_tuser,
   output logic [DSTW-1:0]   m_tdest,
   output logic [IW-1:0]     m_tid,
   output logic              m_tlast,
   output logic              m_tvalid,
   input  logic              m_tready
);

   localparam int unsigned PW = DW + 2 * (DW / 8) + UW + DSTW + IW + 1;

   logic [PW-1:0] in_w;
   logic [PW-1:0] out_q;
   logic [PW-1:0] skid_q;
   logic          out_v_q;
   logic          skid_v_q;
   logic          push;
   logic          pop;

   assign in_w     = {s_tdata, s_tkeep, s_tstrb, s_tuser, s_tdest, s_tid, s_tlast};
   assign s_tready = !skid_v_q;
   assign push     = s_tvalid && !skid_v_q;
   assign pop      = out_v_q && m_tready;

   assign {m_tdata, m_tkeep, m_tstrb, m_tuser, m_tdest, m_tid, m_tlast} = out_q;
   assign m_tvalid = out_v_q;

   // The output stage only reloads when empty or draining, keeping payload stable under stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q    <= '0;
         skid_q   <= '0;
         out_v_q  <= 1'b0;
         skid_v_q <= 1'b0;
      end else if (!out_v_q || pop) begin
         if (skid_v_q) begin
            out_q    <= skid_q;
            out_v_q  <= 1'b1;
            skid_v_q <= push;
            if (push) skid_q <= in_w;
         end else begin
            out_v_q <= push;
            if (push) out_q <= in_w;
         end
      end else if (push) begin
         skid_q   <= in_w;
         skid_v_q <= 1'b1;
      end
   end

endmodule

// File: rtl/axis_rr_mux.sv
// N-to-1 AXI-Stream multiplexer with packet-level round-robin arbitration and
// a skid-buffered output; the IDLE decision accepts the winner's beat in the same cycle.
module axis_rr_mux
   import axis_pkg::*;
#(
   parameter int unsigned N       = AXIS_DEF_N,
   parameter int unsigned DW      = AXIS_DEF_DW,
   parameter int unsigned UW      = AXIS_DEF_UW,
   parameter int unsigned DSTW    = AXIS_DEF_DSTW,
   parameter int unsigned IW      = AXIS_DEF_IW,
   parameter int unsigned ID_MODE = ID_MODE_INDEX
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*DW-1:0]      s_tdata,
   input  logic [N*(DW/8)-1:0]  s_tkeep,
   input  logic [N*(DW/8)-1:0]  s_tstrb,
   input  logic [N*UW-1:0]      s_tuser,
   input  logic [N*DSTW-1:0]    s_tdest,
   input  logic [N*IW-1:0]      s_tid,
   input  logic [N-1:0]         s_tvalid,
   input  logic [N-1:0]         s_tlast,
   output logic [N-1:0]         s_tready,
   output logic [DW-1:0]        m_tdata,
   output logic [DW/8-1:0]      m_tkeep,
   output logic [DW/8-1:0]      m_tstrb,
   output logic [UW-1:0]        m_tuser,
   output logic [DSTW-1:0]      m_tdest,
   output logic [IW-1:0]        m_tid,
   output logic                 m_tvalid,
   output logic                 m_tlast,
   input  logic                 m_tready
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned GW = clog2(N);

   arb_state_e      state_q;
   logic [GW-1:0]   g_q;
   logic [GW-1:0]   win;
   logic [GW-1:0]   cand;
   logic            found;
   logic            buf_ready;
   logic            accept;
   logic [IW-1:0]   sel_tid;

   // In LOCK the owner keeps the grant even while its tvalid is low.
   always_comb begin
      win   = g_q;
      cand  = g_q;
      found = 1'b0;
      if (state_q == ARB_LOCK) begin
         found = 1'b1;
      end else begin
         for (int unsigned k = 1; k <= N; k++) begin
            cand = GW'((32'(g_q) + k) % N);
            if (!found && s_tvalid[cand]) begin
               win   = cand;
               found = 1'b1;
            end
         end
      end
   end

   assign accept = found && buf_ready && s_tvalid[win] && !rst;

   always_comb begin
      s_tready = '0;
      if (found && buf_ready && !rst) s_tready[win] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         g_q     <= GW'(N - 1);
      end else if (accept) begin
         g_q <= win;
         case (state_q)
            ARB_IDLE: if (!s_tlast[win]) state_q <= ARB_LOCK;
            ARB_LOCK: if (s_tlast[win])  state_q <= ARB_IDLE;
            default:                     state_q <= ARB_IDLE;
         endcase
      end
   end

   assign sel_tid = (ID_MODE == ID_MODE_PASS) ? s_tid[win*IW +: IW] : IW'(win);

   axis_skid_buf #(
      .DW   (DW),
      .UW   (UW),
      .DSTW (DSTW),
      .IW   (IW)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .s_tdata  (s_tdata[win*DW +: DW]),
      .s_tkeep  (s_tkeep[win*SW +: SW]),
      .s_tstrb  (s_tstrb[win*SW +: SW]),
      .s_tuser  (s_tuser[win*UW +: UW]),
      .s_tdest  (s_tdest[win*DSTW +: DSTW]),
      .s_tid    (sel_tid),
      .s_tlast  (s_tlast[win]),
      .s_tvalid (accept),
      .s_tready (buf_ready),
      .m_tdata  (m_tdata),
      .m_tkeep  (m_tkeep),
      .m_tstrb  (m_tstrb),
      .m_tuser  (m_tuser),
      .m_tdest  (m_tdest),
      .m_tid    (m_tid),
      .m_tlast  (m_tlast),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready)
   );

endmodule

// File: tb/tb_axis_rr_mux.sv
// Directed bench for axis_rr_mux: hand-ordered expected beats go into a scoreboard
// that a negedge monitor drains; a second instance runs in tid pass-through mode.
`timescale 1ns/1ps
module tb_axis_rr_mux;

   localparam int N = 4, DW = 32, SW = 4, UW = 1, DSTW = 1, IW = 4;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic [3:0]  sid;
      int          gap;
   } beat_t;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic [1:0]  ch;
      logic [3:0]  sid;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N*DW-1:0]   s_tdata  = '0;
   logic [N*SW-1:0]   s_tkeep  = '0;
   logic [N*SW-1:0]   s_tstrb  = '0;
   logic [N*UW-1:0]   s_tuser  = '0;
   logic [N*DSTW-1:0] s_tdest  = '0;
   logic [N*IW-1:0]   s_tid    = '0;
   logic [N-1:0]      s_tvalid = '0;
   logic [N-1:0]      s_tlast  = '0;
   logic [N-1:0]      s_tready, p_s_tready;
   logic [DW-1:0]     m_tdata, p_tdata;
   logic [SW-1:0]     m_tkeep, p_tkeep, m_tstrb, p_tstrb;
   logic [UW-1:0]     m_tuser, p_tuser;
   logic [DSTW-1:0]   m_tdest, p_tdest;
   logic [IW-1:0]     m_tid, p_tid;
   logic              m_tvalid, p_tvalid, m_tlast, p_tlast;
   logic              m_tready = 1'b0;

   axis_rr_mux #(.N(N), .DW(DW), .UW(UW), .DSTW(DSTW), .IW(IW), .ID_MODE(1)) dut (
      .clk(clk), .rst(rst),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tstrb(s_tstrb), .s_tuser(s_tuser),
      .s_tdest(s_tdest), .s_tid(s_tid), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tstrb(m_tstrb), .m_tuser(m_tuser),
      .m_tdest(m_tdest), .m_tid(m_tid), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
      .m_tready(m_tready)
   );

   axis_rr_mux #(.N(N), .DW(DW), .UW(UW), .DSTW(DSTW), .IW(IW), .ID_MODE(0)) dut_pass (
      .clk(clk), .rst(rst),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tstrb(s_tstrb), .s_tuser(s_tuser),
      .s_tdest(s_tdest), .s_tid(s_tid), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .s_tready(p_s_tready),
      .m_tdata(p_tdata), .m_tkeep(p_tkeep), .m_tstrb(p_tstrb), .m_tuser(p_tuser),
      .m_tdest(p_tdest), .m_tid(p_tid), .m_tvalid(p_tvalid), .m_tlast(p_tlast),
      .m_tready(m_tready)
   );

   beat_t       src_q[N][$];
   exp_t        sb[$];
   int          stamps[$];
   int          wait_c[N];
   logic [N-1:0] hs_q = '0;
   logic [N-1:0] rdy_snap = '0;
   logic        mv_snap = 1'b0;
   logic        mtr_set = 1'b1;
   logic        rst_set = 1'b1;
   int          ncnt = 0;
   int          first_hs = -1;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [3:0] keep_of(input logic [1:0] c);
      return 4'hF ^ {2'b00, c};
   endfunction

   function automatic logic [3:0] strb_of(input logic [1:0] c);
      return {2'b00, c} + 4'd1;
   endfunction

   always @(posedge clk) ncnt <= ncnt + 1;

   // Monitor: pops one expected beat per output handshake, and checks stall stability.
   logic        stall_q = 1'b0;
   logic [31:0] stall_data = '0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            checks++;
            if (!m_tvalid || m_tdata !== stall_data) begin
               errors++;
               $display("FAIL stall_hold got valid=%0b data=%h required valid=1 data=%h",
                        m_tvalid, m_tdata, stall_data);
            end
         end
         if (m_tvalid && m_tready) begin
            checks++;
            stamps.push_back(ncnt);
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat got data=%h required no beat", m_tdata);
            end else begin
               e = sb.pop_front();
               if (m_tdata !== e.data || m_tlast !== e.last || m_tkeep !== keep_of(e.ch) ||
                   m_tstrb !== strb_of(e.ch) || m_tuser !== e.ch[0] || m_tdest !== e.ch[1] ||
                   m_tid !== {2'b00, e.ch} || !p_tvalid || p_tdata !== e.data || p_tid !== e.sid) begin
                  errors++;
                  $display("FAIL beat got data=%h last=%0b keep=%h strb=%h tid=%h pass_tid=%h pass_data=%h required data=%h last=%0b keep=%h strb=%h tid=%h pass_tid=%h",
                           m_tdata, m_tlast, m_tkeep, m_tstrb, m_tid, p_tid, p_tdata,
                           e.data, e.last, keep_of(e.ch), strb_of(e.ch), {2'b00, e.ch}, e.sid);
               end
            end
         end
         stall_q    = m_tvalid && !m_tready;
         stall_data = m_tdata;
      end
   end

   task automatic cyc();
      beat_t b;
      @(posedge clk);
      #1;
      rst      = rst_set;
      m_tready = mtr_set;
      for (int i = 0; i < N; i++) begin
         if (hs_q[i] && src_q[i].size() > 0) begin
            b = src_q[i].pop_front();
            if (src_q[i].size() > 0) wait_c[i] = src_q[i][0].gap;
         end
         if (src_q[i].size() > 0 && wait_c[i] == 0) begin
            b = src_q[i][0];
            s_tdata[i*DW +: DW] = b.data;
            s_tkeep[i*SW +: SW] = keep_of(2'(i));
            s_tstrb[i*SW +: SW] = strb_of(2'(i));
            s_tuser[i]          = (i % 2) == 1;
            s_tdest[i]          = i >= 2;
            s_tid[i*IW +: IW]   = b.sid;
            s_tlast[i]          = b.last;
            s_tvalid[i]         = 1'b1;
         end else begin
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
            if (wait_c[i] > 0 && src_q[i].size() > 0) wait_c[i]--;
         end
      end
      @(negedge clk);
      hs_q     = s_tvalid & s_tready;
      rdy_snap = s_tready;
      mv_snap  = m_tvalid;
      if (hs_q != '0 && first_hs < 0) first_hs = ncnt;
   endtask

   task automatic src(input int ch, input logic [31:0] d, input logic l,
                      input logic [3:0] sid, input int gap);
      beat_t b;
      b.data = d; b.last = l; b.sid = sid; b.gap = gap;
      if (src_q[ch].size() == 0) wait_c[ch] = gap;
      src_q[ch].push_back(b);
   endtask

   task automatic expb(input int ch, input logic [31:0] d, input logic l, input logic [3:0] sid);
      exp_t e;
      e.data = d; e.last = l; e.ch = 2'(ch); e.sid = sid;
      sb.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h", nm, got, req);
      end
   endtask

   function automatic bit busy();
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
      return sb.size() > 0;
   endfunction

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (busy() && n < 200) begin
         cyc();
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL %s_drain got pending=%0d required pending=0", nm, sb.size());
      end
      cyc();
      cyc();
   endtask

   task automatic chk_timing(input string nm, input int d[$]);
      bit ok;
      ok = (stamps.size() == d.size());
      for (int k = 0; k < d.size() && ok; k++)
         if (stamps[k] != first_hs + 1 + d[k]) ok = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s got beats=%0d first_offset=%0d last_offset=%0d required beats=%0d first_offset=%0d last_offset=%0d",
                  nm, stamps.size(),
                  (stamps.size() > 0) ? stamps[0] - first_hs - 1 : -1,
                  (stamps.size() > 0) ? stamps[stamps.size()-1] - first_hs - 1 : -1,
                  d.size(), d[0], d[d.size()-1]);
      end
   endtask

   task automatic new_test();
      first_hs = -1;
      stamps.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d[$];
      for (int i = 0; i < N; i++) wait_c[i] = 0;

      // Reset state
      rst_set = 1'b1; mtr_set = 1'b1;
      cyc(); cyc();
      chk("rst_mvalid", 32'(mv_snap), 0);
      chk("rst_sready", 32'(rdy_snap), 0);
      rst_set = 1'b0;
      cyc();
      chk("post_rst_mvalid", 32'(m_tvalid), 0);
      chk("post_rst_mdata", m_tdata, 0);
      chk("post_rst_sready", 32'(rdy_snap), 0);

      // Single-beat packets on all channels: served 0..3, one per cycle
      new_test();
      for (int i = 0; i < N; i++) src(i, 32'h10 + 32'(i), 1'b1, (i == 2) ? 4'hA : 4'(i + 5), 0);
      expb(0, 32'h10, 1'b1, 4'h5);
      expb(1, 32'h11, 1'b1, 4'h6);
      expb(2, 32'h12, 1'b1, 4'hA);
      expb(3, 32'h13, 1'b1, 4'h8);
      drain("rr4");
      d = {0, 1, 2, 3};
      chk_timing("rr4_timing", d);

      // Channel 1 4-beat packet holds lock against channel 2
      new_test();
      for (int k = 0; k < 4; k++) src(1, 32'h100 + 32'(k), k == 3, 4'h3, 0);
      src(2, 32'h200, 1'b1, 4'h9, 1);
      for (int k = 0; k < 4; k++) expb(1, 32'h100 + 32'(k), k == 3, 4'h3);
      expb(2, 32'h200, 1'b1, 4'h9);
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("lock_ready_ch1_only", 32'(rdy_snap), 32'h2);
      end
      drain("lock");
      d = {0, 1, 2, 3, 4};
      chk_timing("lock_timing", d);

      // Channel 0 bubbles mid-packet, channel 3 waits
      new_test();
      src(0, 32'h300, 1'b0, 4'h1, 0);
      src(0, 32'h301, 1'b0, 4'h1, 3);
      src(0, 32'h302, 1'b1, 4'h1, 0);
      src(3, 32'h3F0, 1'b1, 4'h7, 1);
      expb(0, 32'h300, 1'b0, 4'h1);
      expb(0, 32'h301, 1'b0, 4'h1);
      expb(0, 32'h302, 1'b1, 4'h1);
      expb(3, 32'h3F0, 1'b1, 4'h7);
      cyc();
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("bubble_ready_ch0_only", 32'(rdy_snap), 32'h1);
      end
      drain("bubble");
      d = {0, 4, 5, 6};
      chk_timing("bubble_timing", d);

      // Backpressure 1,0,0,1 on a channel 1 burst
      new_test();
      for (int k = 0; k < 4; k++) src(1, 32'h400 + 32'(k), k == 3, 4'h2, 0);
      for (int k = 0; k < 4; k++) expb(1, 32'h400 + 32'(k), k == 3, 4'h2);
      mtr_set = 1'b1; cyc(); chk("bp_ready_c0", 32'(rdy_snap), 32'h2);
      mtr_set = 1'b0; cyc(); chk("bp_ready_c1", 32'(rdy_snap), 32'h2);
      mtr_set = 1'b0; cyc(); chk("bp_ready_c2", 32'(rdy_snap), 32'h0);
      chk("bp_mvalid_c2", 32'(mv_snap), 1);
      mtr_set = 1'b1; cyc(); chk("bp_ready_c3", 32'(rdy_snap), 32'h0);
      cyc(); chk("bp_ready_c4", 32'(rdy_snap), 32'h2);
      drain("bp");
      d = {2, 3, 4, 5};
      chk_timing("bp_timing", d);

      // Reset on beat 2 of a 5-beat packet discards everything buffered
      new_test();
      mtr_set = 1'b0;
      for (int k = 0; k < 5; k++) src(2, 32'h500 + 32'(k), k == 4, 4'h4, 0);
      cyc();
      chk("rst_mid_ready_c0", 32'(rdy_snap), 32'h4);
      rst_set = 1'b1;
      cyc();
      chk("rst_mid_ready_during", 32'(rdy_snap), 0);
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         wait_c[i] = 0;
      end
      hs_q = '0;
      rst_set = 1'b0; mtr_set = 1'b1;
      cyc();
      chk("rst_mid_mvalid_after", 32'(mv_snap), 0);
      chk("rst_mid_ready_after", 32'(rdy_snap), 0);
      chk("rst_mid_mdata_after", m_tdata, 0);
      new_test();
      src(0, 32'h5A0, 1'b1, 4'h1, 0);
      src(2, 32'h5B0, 1'b1, 4'h2, 0);
      expb(0, 32'h5A0, 1'b1, 4'h1);
      expb(2, 32'h5B0, 1'b1, 4'h2);
      cyc();
      chk("rst_regrant_ch0", 32'(rdy_snap), 32'h1);
      drain("rst_mid");
      d = {0, 1};
      chk_timing("rst_mid_timing", d);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
